// File: rtl/microstore_pkg.sv
// Shared definitions for the microstore sequencer: sequencing-field encodings,
// FSM states and microword field offsets derived from the address width.
package microstore_pkg;

   // Next-address select codes held in the NSEL field of each microword
   typedef enum logic [2:0] {
      NSEL_INC   = 3'd0,
      NSEL_JMP   = 3'd1,
      NSEL_DISP  = 3'd2,
      NSEL_CBR   = 3'd3,
      NSEL_CALL  = 3'd4,
      NSEL_RET   = 3'd5,
      NSEL_FETCH = 3'd6,
      NSEL_WAITM = 3'd7
   } nsel_e;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_WAIT  = 2'd3
   } state_e;

   // Field offsets within a microword; TARGET occupies [addr_w-1:0]
   function automatic int nsel_lsb(input int addr_w);
      return addr_w;
   endfunction

   function automatic int cinv_bit(input int addr_w);
      return addr_w + 3;
   endfunction

   function automatic int csel_lsb(input int addr_w);
      return addr_w + 4;
   endfunction

endpackage

// File: rtl/microstore_stack.sv
// Return-address LIFO for microprogram CALL/RET. A push into a full stack or a
// pop from an empty one is dropped and flagged for that cycle.
module microstore_stack #(
   parameter int DEPTH_D = 4,
   parameter int DATA_W  = 7
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] top_o,
   output logic              full_o,
   output logic              empty_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam int PTR_W = $clog2(DEPTH_D);

   logic [PTR_W:0]    sp_q, sp_d;
   logic [PTR_W-1:0]  top_idx;
   logic [DATA_W-1:0] mem_q [DEPTH_D];
   logic              do_push, do_pop;

   assign full_o      = (sp_q == (PTR_W+1)'(DEPTH_D));
   assign empty_o     = (sp_q == '0);
   assign do_push     = push_i && !full_o;
   assign do_pop      = pop_i && !empty_o;
   assign overflow_o  = push_i && full_o;
   assign underflow_o = pop_i && empty_o;
   assign top_idx     = sp_q[PTR_W-1:0] - PTR_W'(1);
   assign top_o       = mem_q[top_idx];

   // Next stack-pointer value
   always_comb begin
      // NOTE: assign a default first so every path drives sp_d; otherwise a latch is inferred.
      sp_d = sp_q;
      if (do_push)
         sp_d = sp_q + (PTR_W+1)'(1);
      else if (do_pop)
         sp_d = sp_q - (PTR_W+1)'(1);
   end

   // Stack-pointer register
   always_ff @(posedge clk_i or posedge reset_i) begin
      // NOTE: registers take non-blocking assignments so all flops update from pre-edge values.
      if (reset_i)
         sp_q <= '0;
      else
         sp_q <= sp_d;
   end

   // Stack storage write
   always_ff @(posedge clk_i) begin
      // NOTE: storage is deliberately not reset; the pointer alone defines which entries are valid.
      if (do_push)
         mem_q[sp_q[PTR_W-1:0]] <= data_i;
   end

endmodule

// File: rtl/microstore_sequencer.sv
// Writable control store plus microprogram sequencer. Loads microwords while
// idle, then fetches one microword per cycle into uir, choosing the next
// microaddress from the sequencing fields of the current word.
module microstore_sequencer
   import microstore_pkg::*;
#(
   parameter int ADDR_W     = 7,
   parameter int WORD_W     = 45,
   parameter int STACK_D    = 4,
   parameter int RESET_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run_i,
   input  logic              load_en_i,
   input  logic [ADDR_W-1:0] load_addr_i,
   input  logic [WORD_W-1:0] load_data_i,
   input  logic [ADDR_W-1:0] dispatch_addr_i,
   input  logic [3:0]        cond_i,
   input  logic              mem_ready_i,
   output logic [WORD_W-1:0] ctrl_word_o,
   output logic              ctrl_valid_o,
   output logic [ADDR_W-1:0] upc_o,
   output logic              stack_err_o
);

   localparam int DEPTH    = 2**ADDR_W;
   localparam int NSEL_LSB = nsel_lsb(ADDR_W);
   localparam int CINV_BIT = cinv_bit(ADDR_W);
   localparam int CSEL_LSB = csel_lsb(ADDR_W);

   logic [WORD_W-1:0] store_q [DEPTH];

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] upc_q, upc_d;
   logic [WORD_W-1:0] uir_q, uir_d;
   logic              stack_err_q, stack_err_d;

   logic [ADDR_W-1:0] target, upc_inc, next_addr, stack_top;
   nsel_e             nsel;
   logic              cinv, active, hold, store_we;
   logic [1:0]        csel;
   logic              push, pop, stack_full, stack_empty, overflow, underflow;

   assign target  = uir_q[ADDR_W-1:0];
   assign nsel    = nsel_e'(uir_q[NSEL_LSB +: 3]);
   assign cinv    = uir_q[CINV_BIT];
   assign csel    = uir_q[CSEL_LSB +: 2];
   assign upc_inc = upc_q + ADDR_W'(1);
   assign active  = (state_q == ST_RUN) || (state_q == ST_WAIT);

   microstore_stack #(
      .DEPTH_D (STACK_D),
      .DATA_W  (ADDR_W)
   ) u_stack (
      .clk_i       (clk),
      .reset_i     (reset),
      .push_i      (push),
      .pop_i       (pop),
      .data_i      (upc_inc),
      .top_o       (stack_top),
      .full_o      (stack_full),
      .empty_o     (stack_empty),
      .overflow_o  (overflow),
      .underflow_o (underflow)
   );

   // Next microaddress and stack requests from the sequencing fields of uir
   always_comb begin
      next_addr = upc_inc;
      push      = 1'b0;
      pop       = 1'b0;
      hold      = 1'b0;
      unique case (nsel)
         NSEL_INC:   next_addr = upc_inc;
         NSEL_JMP:   next_addr = target;
         NSEL_DISP:  next_addr = dispatch_addr_i;
         NSEL_CBR:   next_addr = (cond_i[csel] ^ cinv) ? target : upc_inc;
         NSEL_CALL: begin
            push      = active;
            next_addr = target;
         end
         NSEL_RET: begin
            pop       = active;
            next_addr = stack_empty ? ADDR_W'(RESET_ADDR) : stack_top;
         end
         NSEL_FETCH: next_addr = ADDR_W'(RESET_ADDR);
         NSEL_WAITM: begin
            hold      = !mem_ready_i;
            next_addr = upc_inc;
         end
      endcase
   end

   // Sequencer FSM: state, upc and uir next values
   always_comb begin
      state_d  = state_q;
      upc_d    = upc_q;
      uir_d    = uir_q;
      store_we = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            store_we = load_en_i;
            if (run_i)
               state_d = ST_PRIME;
         end
         ST_PRIME: begin
            uir_d   = store_q[upc_q];
            state_d = ST_RUN;
         end
         ST_RUN, ST_WAIT: begin
            if (!hold) begin
               upc_d = next_addr;
               uir_d = store_q[next_addr];
            end
            if (!run_i)
               state_d = ST_IDLE;
            else if (hold)
               state_d = ST_WAIT;
            else
               state_d = ST_RUN;
         end
      endcase
   end

   // Stack error is sticky until reset
   assign stack_err_d = stack_err_q | overflow | underflow;

   // Sequencer registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         upc_q       <= ADDR_W'(RESET_ADDR);
         uir_q       <= '0;
         stack_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         upc_q       <= upc_d;
         uir_q       <= uir_d;
         stack_err_q <= stack_err_d;
      end
   end

   // Control-store write port, open only while idle
   always_ff @(posedge clk) begin
      if (store_we)
         store_q[load_addr_i] <= load_data_i;
   end

   assign ctrl_word_o  = uir_q;
   assign ctrl_valid_o = active;
   assign upc_o        = upc_q;
   assign stack_err_o  = stack_err_q;

endmodule

// File: tb/tb_microstore_sequencer.sv
// Self-checking bench for microstore_sequencer: directed scenarios with fixed
// expectations plus randomized traffic compared against a behavioural model.
module tb_microstore_sequencer;

   localparam int ADDR_W  = 7;
   localparam int WORD_W  = 45;
   localparam int STACK_D = 4;
   localparam int DEPTH   = 128;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              run = 1'b0;
   logic              load_en = 1'b0;
   logic [ADDR_W-1:0] load_addr = '0;
   logic [WORD_W-1:0] load_data = '0;
   logic [ADDR_W-1:0] dispatch_addr = '0;
   logic [3:0]        cond = '0;
   logic              mem_ready = 1'b0;
   logic [WORD_W-1:0] ctrl_word;
   logic              ctrl_valid;
   logic [ADDR_W-1:0] upc;
   logic              stack_err;

   microstore_sequencer #(
      .ADDR_W     (ADDR_W),
      .WORD_W     (WORD_W),
      .STACK_D    (STACK_D),
      .RESET_ADDR (0)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .run_i           (run),
      .load_en_i       (load_en),
      .load_addr_i     (load_addr),
      .load_data_i     (load_data),
      .dispatch_addr_i (dispatch_addr),
      .cond_i          (cond),
      .mem_ready_i     (mem_ready),
      .ctrl_word_o     (ctrl_word),
      .ctrl_valid_o    (ctrl_valid),
      .upc_o           (upc),
      .stack_err_o     (stack_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // mode: 0 = halted/loading, 1 = priming, 2 = sequencing (RUN or WAIT)
   int                m_mode;
   logic [ADDR_W-1:0] m_upc;
   logic [WORD_W-1:0] m_uir;
   logic [WORD_W-1:0] m_mem [DEPTH];
   int                m_stk [$];
   logic              m_err;

   task automatic model_reset();
      m_mode = 0;
      m_upc  = '0;
      m_uir  = '0;
      m_err  = 1'b0;
      m_stk.delete();
   endtask

   task automatic model_edge();
      int tgt, nsel, cinv, csel, nx;
      bit hold;
      case (m_mode)
         0: begin
            if (load_en) m_mem[load_addr] = load_data;
            if (run) m_mode = 1;
         end
         1: begin
            m_uir  = m_mem[m_upc];
            m_mode = 2;
         end
         default: begin
            tgt  = int'(m_uir % 128);
            nsel = int'((m_uir >> 7) % 8);
            cinv = int'((m_uir >> 10) % 2);
            csel = int'((m_uir >> 11) % 4);
            nx   = (int'(m_upc) + 1) % DEPTH;
            hold = 0;
            case (nsel)
               1: nx = tgt;
               2: nx = int'(dispatch_addr);
               3: if ((int'(cond[csel]) ^ cinv) != 0) nx = tgt;
               4: begin
                  if (m_stk.size() < STACK_D) m_stk.push_back((int'(m_upc) + 1) % DEPTH);
                  else m_err = 1'b1;
                  nx = tgt;
               end
               5: begin
                  if (m_stk.size() > 0) nx = m_stk.pop_back();
                  else begin
                     nx    = 0;
                     m_err = 1'b1;
                  end
               end
               6: nx = 0;
               7: hold = !mem_ready;
               default: ;
            endcase
            if (!hold) begin
               m_upc = ADDR_W'(nx);
               m_uir = m_mem[m_upc];
            end
            if (!run) m_mode = 0;
         end
      endcase
   endtask

   task automatic compare_all();
      check("upc", 64'(upc), 64'(m_upc));
      check("ctrl_word", 64'(ctrl_word), 64'(m_uir));
      check("ctrl_valid", 64'(ctrl_valid), 64'(m_mode == 2));
      check("stack_err", 64'(stack_err), 64'(m_err));
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic logic [WORD_W-1:0] mkword(input int nsel, input int tgt,
                                                input int csel, input int cinv);
      logic [31:0] ctl;
      ctl = $urandom();
      return {ctl, 2'(csel), 1'(cinv), 3'(nsel), 7'(tgt)};
   endfunction

   // One clock: the model follows the edge, outputs are compared on the falling edge
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic load_word(input int addr, input logic [WORD_W-1:0] w);
      load_en   = 1'b1;
      load_addr = ADDR_W'(addr);
      load_data = w;
      step();
      load_en   = 1'b0;
   endtask

   // Asynchronous reset pulse placed between clock edges
   task automatic async_reset();
      run = 1'b0;
      #2 reset = 1'b1;
      model_reset();
      #1 compare_all();
      #1 reset = 1'b0;
   endtask

   // run=1: one PRIME cycle, then the first RUN cycle
   task automatic run_start();
      run = 1'b1;
      step();
      check("prime_valid", 64'(ctrl_valid), 64'd0);
      step();
      check("run_valid", 64'(ctrl_valid), 64'd1);
   endtask

   logic [WORD_W-1:0] w5, w1, w7f;
   int seq_a [7]    = '{0, 1, 2, 3, 4, 0, 1};
   int seq_stk [10] = '{'h20, 'h30, 'h40, 'h50, 'h60, 'h41, 'h31, 'h21, 'h01, 'h00};

   initial begin
      model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_upc", 64'(upc), 64'd0);
      check("rst_valid", 64'(ctrl_valid), 64'd0);
      check("rst_word", 64'(ctrl_word), 64'd0);
      check("rst_serr", 64'(stack_err), 64'd0);

      // Fill the whole store with random microwords
      for (int a = 0; a < DEPTH; a++)
         load_word(a, mkword($urandom_range(0, 7), $urandom_range(0, 127),
                             $urandom_range(0, 3), $urandom_range(0, 1)));

      // Straight-line sequence with a loop back to 0
      for (int a = 0; a < 4; a++) load_word(a, mkword(0, $urandom_range(0, 127), 0, 0));
      load_word(4, mkword(1, 0, 0, 0));
      w5 = mkword(0, 0, 0, 0);
      load_word(5, w5);
      run_start();
      for (int i = 0; i < 7; i++) begin
         check("seq_upc", 64'(upc), 64'(seq_a[i]));
         if (i < 6) step();
      end

      // Reset mid-RUN, then show word 5 survived
      async_reset();
      check("midrst_upc", 64'(upc), 64'd0);
      check("midrst_valid", 64'(ctrl_valid), 64'd0);
      step();
      check("idle_valid", 64'(ctrl_valid), 64'd0);
      load_word(0, mkword(1, 5, 0, 0));
      run_start();
      step();
      check("keep_upc", 64'(upc), 64'd5);
      check("keep_word", 64'(ctrl_word), 64'(w5));
      run = 1'b0;
      step();

      // Dispatch followed by a conditional branch, taken and not taken
      load_word(0, mkword(2, 0, 0, 0));
      load_word('h2A, mkword(3, 'h10, 2, 0));
      for (int t = 0; t < 2; t++) begin
         async_reset();
         dispatch_addr = 7'h2A;
         cond = (t == 0) ? 4'b0100 : 4'b0000;
         run_start();
         step();
         check("disp_upc", 64'(upc), 64'h2A);
         step();
         check("cbr_upc", 64'(upc), (t == 0) ? 64'h10 : 64'h2B);
      end

      // Memory-wait hold
      async_reset();
      load_word(0, mkword(0, 0, 0, 0));
      w1 = mkword(7, 0, 0, 0);
      load_word(1, w1);
      mem_ready = 1'b0;
      run_start();
      step();
      check("waitm_upc", 64'(upc), 64'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("wait_upc", 64'(upc), 64'd1);
         check("wait_word", 64'(ctrl_word), 64'(w1));
         check("wait_valid", 64'(ctrl_valid), 64'd1);
      end
      mem_ready = 1'b1;
      step();
      check("wait_done_upc", 64'(upc), 64'd2);

      // Nested calls past the stack depth, then unwinding past empty
      async_reset();
      load_word(0, mkword(4, 'h20, 0, 0));
      load_word('h20, mkword(4, 'h30, 0, 0));
      load_word('h30, mkword(4, 'h40, 0, 0));
      load_word('h40, mkword(4, 'h50, 0, 0));
      load_word('h50, mkword(4, 'h60, 0, 0));
      load_word('h60, mkword(5, 0, 0, 0));
      load_word('h41, mkword(5, 0, 0, 0));
      load_word('h31, mkword(5, 0, 0, 0));
      load_word('h21, mkword(5, 0, 0, 0));
      load_word('h01, mkword(5, 0, 0, 0));
      run_start();
      for (int i = 0; i < 10; i++) begin
         step();
         check("stk_upc", 64'(upc), 64'(seq_stk[i]));
         check("stk_err", 64'(stack_err), (i >= 4) ? 64'd1 : 64'd0);
      end

      // Address wrap and a load attempt while running
      async_reset();
      load_word(0, mkword(1, 'h7F, 0, 0));
      w7f = mkword(0, 0, 0, 0);
      load_word('h7F, w7f);
      run_start();
      step();
      check("to7f_upc", 64'(upc), 64'h7F);
      step();
      check("wrap_upc", 64'(upc), 64'd0);
      load_en   = 1'b1;
      load_addr = 7'h7F;
      load_data = ~w7f;
      step();
      load_en   = 1'b0;
      check("noload_word", 64'(ctrl_word), 64'(w7f));

      // Randomized traffic against the model
      async_reset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 199) == 0) async_reset();
         run           = ($urandom_range(0, 9) != 0);
         load_en       = ($urandom_range(0, 4) == 0);
         load_addr     = ADDR_W'($urandom_range(0, 127));
         load_data     = mkword($urandom_range(0, 7), $urandom_range(0, 127),
                                $urandom_range(0, 3), $urandom_range(0, 1));
         dispatch_addr = ADDR_W'($urandom_range(0, 127));
         cond          = 4'($urandom_range(0, 15));
         mem_ready     = ($urandom_range(0, 2) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/microstore_sequencer.md
Name: microstore_sequencer

Overview:
- Parametrised successor to the fixed 128x45 control-store ROM: a writable control store plus microprogram sequencer for the microprogrammed CU.
- Holds DEPTH microwords of WORD_W bits and keeps a microprogram counter (upc) and microinstruction register (uir).
- Computes the next microaddress from sequencing fields in the current word: increment, jump, opcode dispatch, conditional branch, call/return, memory-wait hold.
- Sits between the instruction decoder (dispatch address) and the datapath (control word).

Parameters:
ADDR_W, 7, microaddress width; DEPTH = 2**ADDR_W
WORD_W, 45, microword width; must be >= ADDR_W+6
STACK_D, 4, return-stack depth (power of 2, >= 2)
RESET_ADDR, 0, microaddress fetched after reset and on FETCH

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
run  in  1  1 = sequence; 0 = halt and allow store loading
load_en  in  1  write strobe for control store, honoured only in IDLE
load_addr  in  ADDR_W  write address
load_data  in  WORD_W  write data
dispatch_addr  in  ADDR_W  opcode-mapped entry address from decoder
cond  in  4  condition inputs (flags/decoder tests)
mem_ready  in  1  memory-operation-complete (MOC)
ctrl_word  out  WORD_W  current uir contents driven to datapath
ctrl_valid  out  1  high in RUN and WAIT
upc  out  ADDR_W  address of the word currently in uir
stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Field layout of uir, LSB first:
  - [ADDR_W-1:0] = TARGET
  - [ADDR_W+2:ADDR_W] = NSEL
  - [ADDR_W+3] = CINV
  - [ADDR_W+5:ADDR_W+4] = CSEL
  - remaining bits = datapath controls, passed through unchanged.
- NSEL encodings:
  - 0 INC: upc+1, wraps modulo DEPTH.
  - 1 JMP: TARGET.
  - 2 DISP: dispatch_addr.
  - 3 CBR: TARGET if cond[CSEL]^CINV, else upc+1.
  - 4 CALL: push upc+1, go to TARGET.
  - 5 RET: pop.
  - 6 FETCH: RESET_ADDR.
  - 7 WAITM: stay on the current word until mem_ready=1, then upc+1.
- FSM states: IDLE, PRIME, RUN, WAIT.
- Reset (async, any state):
  - state=IDLE, upc=RESET_ADDR, uir=0, stack pointer=0, stack_err=0, ctrl_valid=0.
  - Store contents are not cleared.
- IDLE:
  - load_en writes store[load_addr] on the clock edge.
  - run=1 -> PRIME.
  - load_en in any other state is ignored.
- PRIME: uir<=store[upc], go to RUN. One cycle of latency; ctrl_valid=0.
- RUN, each edge:
  - upc<=next, uir<=store[next]; one microinstruction per cycle.
  - NSEL=WAITM with mem_ready=0 -> WAIT; uir and upc are held.
  - WAITM with mem_ready=1 advances immediately with no WAIT cycle.
- WAIT:
  - Holds until mem_ready=1, then advances to upc+1 and returns to RUN.
  - ctrl_word stays stable throughout.
- run=0 in RUN or WAIT:
  - Completes the current edge's advance, then enters IDLE.
  - upc is retained, so a later run=1 re-primes from that address.
- Stack:
  - CALL when full: push dropped, stack_err set, jump still taken.
  - RET when empty: goes to RESET_ADDR, stack_err set.
  - stack_err clears only on reset.
- Read-during-load is impossible, because loading is restricted to IDLE.

Decomposition:
- Shared package holds:
  - NSEL encodings (NSEL_INC ... NSEL_WAITM)
  - field offset constants derived from ADDR_W
  - state encodings
- One natural sub-module: microstore_stack, a parametrised LIFO with push, pop, full, empty, overflow and underflow.

Test Plan:
- Reset mid-RUN -> next cycle upc=0, ctrl_valid=0, state IDLE; a previously loaded word at address 5 is still readable after re-run.
- Load words 0..3 with NSEL=INC, word 4 JMP TARGET=0; run=1 -> ctrl_valid rises after one PRIME cycle; upc sequence is 0,1,2,3,4,0,1.
- Word 0 DISP with dispatch_addr=7'h2A -> next upc=0x2A. Word 0x2A CBR CSEL=2 CINV=0 TARGET=0x10: with cond=4'b0100 upc=0x10; with cond=0 upc=0x2B.
- Word 1 WAITM, mem_ready held low 3 cycles -> upc=1 and ctrl_word unchanged for 4 cycles total; upc=2 one edge after mem_ready=1.
- CALL chain with STACK_D=4, 5 nested calls -> stack_err=1 after the 5th; 4 RETs return in LIFO order; 5th RET goes to upc=0.
- Word 0x7F NSEL=INC -> next upc=0x00 (wrap). load_en pulsed during RUN -> store unchanged.
